// File: rtl/gemm_seq_tracker.sv
// rtl/gemm_seq_tracker.sv - control skew, per-bank valid gating and tile tracking for the GEMM array
module gemm_seq_tracker #(
  parameter int ROWS       = 16,
  parameter int COLS       = 16,
  parameter int BANK_COLS  = 4,
  parameter int MUX_W      = 1,
  parameter int STORE_LEAD = 2,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [MUX_W-1:0]                mux_sel,
  input  logic                            psum_valid,
  input  logic [$clog2(COLS+1)-1:0]       n_active,
  input  logic                            store,
  input  logic                            overwrite,
  output logic [ROWS-2:0][MUX_W-1:0]      mux_sel_pipe,
  output logic [COLS/BANK_COLS-1:0]       bank_valid,
  output logic [COLS/BANK_COLS-1:0]       bank_store,
  output logic [COLS/BANK_COLS-1:0]       bank_overwrite,
  output logic                            accum_start,
  output logic                            if_sent,
  output logic                            acc_done,
  output logic                            busy,
  output logic [CNT_W-1:0]                tile_cnt
);

  localparam int NBANK = COLS / BANK_COLS;
  localparam int SD    = COLS - STORE_LEAD;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state, state_nx;
  logic [COLS-1:0] valid_d;
  logic [SD-1:0]   store_d;
  logic [SD-1:0]   ovw_d;
  logic            tail_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mux_sel_pipe <= '0;
      valid_d      <= '0;
      store_d      <= '0;
      ovw_d        <= '0;
      tail_q       <= 1'b0;
    end else begin
      mux_sel_pipe[0] <= mux_sel;
      for (int i = 1; i < ROWS-1; i++) mux_sel_pipe[i] <= mux_sel_pipe[i-1];
      valid_d[0] <= psum_valid;
      for (int j = 1; j < COLS; j++) valid_d[j] <= valid_d[j-1];
      store_d[0] <= store;
      ovw_d[0]   <= overwrite;
      for (int j = 1; j < SD; j++) begin
        store_d[j] <= store_d[j-1];
        ovw_d[j]   <= ovw_d[j-1];
      end
      tail_q <= valid_d[COLS-1];
    end
  end

  // Each bank only needs its enable bit carried as far as its own tap.
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    localparam int TAP  = (b+1)*BANK_COLS - 1;
    localparam int CTAP = (b+1)*BANK_COLS - STORE_LEAD - 1;
    localparam int BASE = b*BANK_COLS;

    logic [TAP:0] en_sr;
    logic         en_now;

    assign en_now = int'(n_active) > BASE;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        en_sr <= '0;
      end else begin
        en_sr[0] <= en_now;
        for (int j = 1; j <= TAP; j++) en_sr[j] <= en_sr[j-1];
      end
    end

    assign bank_valid[b]     = valid_d[TAP] & en_sr[TAP];
    assign bank_store[b]     = store_d[CTAP];
    assign bank_overwrite[b] = ovw_d[CTAP];
  end

  // accum_start is combinational on psum_valid, so it is masked while in reset.
  assign accum_start = rst & psum_valid & ~valid_d[0];
  assign if_sent     = ~psum_valid & valid_d[0];
  assign acc_done    = tail_q & ~valid_d[COLS-1];
  assign busy        = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (psum_valid) state_nx = STREAM;
      STREAM:  if (!psum_valid) state_nx = DRAIN;
      DRAIN: begin
        if (psum_valid)        state_nx = STREAM;
        else if (valid_d == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tile_cnt <= '0;
    end else begin
      state <= state_nx;
      if (acc_done) tile_cnt <= tile_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gemm_seq_tracker.sv
// tb/tb_gemm_seq_tracker.sv - randomized and directed check of gemm_seq_tracker against a history model
module tb_gemm_seq_tracker;

  localparam int ROWS  = 16;
  localparam int COLS  = 16;
  localparam int BC    = 4;
  localparam int NBANK = COLS / BC;
  localparam int SL    = 2;
  localparam int HMAX  = 8192;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [0:0]                 mux_sel = '0;
  logic                       psum_valid = 1'b0;
  logic [4:0]                 n_active = '0;
  logic                       store = 1'b0;
  logic                       overwrite = 1'b0;
  logic [ROWS-2:0][0:0]       mux_sel_pipe;
  logic [NBANK-1:0]           bank_valid, bank_store, bank_overwrite;
  logic                       accum_start, if_sent, acc_done, busy;
  logic [15:0]                tile_cnt;

  logic [ROWS-2:0][0:0]       w_mux_sel_pipe;
  logic [NBANK-1:0]           w_bank_valid, w_bank_store, w_bank_overwrite;
  logic                       w_accum_start, w_if_sent, w_acc_done, w_busy;
  logic [1:0]                 w_tile_cnt;

  gemm_seq_tracker u_dut (
    .clk(clk), .rst(rst), .mux_sel(mux_sel), .psum_valid(psum_valid), .n_active(n_active),
    .store(store), .overwrite(overwrite), .mux_sel_pipe(mux_sel_pipe), .bank_valid(bank_valid),
    .bank_store(bank_store), .bank_overwrite(bank_overwrite), .accum_start(accum_start),
    .if_sent(if_sent), .acc_done(acc_done), .busy(busy), .tile_cnt(tile_cnt)
  );

  gemm_seq_tracker #(.CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst), .mux_sel(mux_sel), .psum_valid(psum_valid), .n_active(n_active),
    .store(store), .overwrite(overwrite), .mux_sel_pipe(w_mux_sel_pipe), .bank_valid(w_bank_valid),
    .bank_store(w_bank_store), .bank_overwrite(w_bank_overwrite), .accum_start(w_accum_start),
    .if_sent(w_if_sent), .acc_done(w_acc_done), .busy(w_busy), .tile_cnt(w_tile_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Input history since the last reset release; index = cycle number.
  bit hv [HMAX];
  int hn [HMAX];
  bit hs [HMAX];
  bit ho [HMAX];
  bit hm [HMAX];
  int t = 0;
  int model_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  function automatic bit v_at(int k); return (k < 0) ? 1'b0 : hv[k]; endfunction
  function automatic int n_at(int k); return (k < 0) ? 0 : hn[k]; endfunction
  function automatic bit s_at(int k); return (k < 0) ? 1'b0 : hs[k]; endfunction
  function automatic bit o_at(int k); return (k < 0) ? 1'b0 : ho[k]; endfunction
  function automatic bit m_at(int k); return (k < 0) ? 1'b0 : hm[k]; endfunction

  task automatic check_outputs(input logic [ROWS-2:0] e_mux, input logic [NBANK-1:0] e_bv,
                               input logic [NBANK-1:0] e_bs, input logic [NBANK-1:0] e_bo,
                               input bit e_st, input bit e_se, input bit e_dn, input bit e_busy,
                               input int e_cnt);
    check("mux_sel_pipe", 32'(mux_sel_pipe), 32'(e_mux));
    check("bank_valid", 32'(bank_valid), 32'(e_bv));
    check("bank_store", 32'(bank_store), 32'(e_bs));
    check("bank_overwrite", 32'(bank_overwrite), 32'(e_bo));
    check("accum_start", 32'(accum_start), 32'(e_st));
    check("if_sent", 32'(if_sent), 32'(e_se));
    check("acc_done", 32'(acc_done), 32'(e_dn));
    check("busy", 32'(busy), 32'(e_busy));
    check("tile_cnt", 32'(tile_cnt), 32'(e_cnt % 65536));
    check("tile_cnt_w2", 32'(w_tile_cnt), 32'(e_cnt % 4));
  endtask

  // One clock cycle: apply inputs, predict every output from the input history, compare at negedge.
  task automatic cyc(input bit pv, input int na, input bit st, input bit ow, input bit mx);
    logic [ROWS-2:0]  e_mux;
    logic [NBANK-1:0] e_bv, e_bs, e_bo;
    bit e_busy, e_dn;
    psum_valid = pv; n_active = 5'(na); store = st; overwrite = ow; mux_sel = mx;
    hv[t] = pv; hn[t] = na; hs[t] = st; ho[t] = ow; hm[t] = mx;
    for (int i = 0; i < ROWS-1; i++) e_mux[i] = m_at(t - i - 1);
    for (int b = 0; b < NBANK; b++) begin
      e_bv[b] = v_at(t - (b+1)*BC) && (n_at(t - (b+1)*BC) > b*BC);
      e_bs[b] = s_at(t - ((b+1)*BC - SL));
      e_bo[b] = o_at(t - ((b+1)*BC - SL));
    end
    e_busy = 1'b0;
    for (int k = t - COLS - 1; k <= t - 1; k++) if (v_at(k)) e_busy = 1'b1;
    e_dn = v_at(t - COLS - 1) && !v_at(t - COLS);
    @(negedge clk);
    check_outputs(e_mux, e_bv, e_bs, e_bo, pv && !v_at(t-1), !pv && v_at(t-1), e_dn, e_busy, model_cnt);
    if (e_dn) model_cnt++;
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      psum_valid = 1'($urandom); n_active = 5'($urandom); store = 1'($urandom);
      overwrite = 1'($urandom); mux_sel = 1'($urandom);
      #1;
      check_outputs('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      @(posedge clk);
      #1;
    end
    psum_valid = 1'b0; n_active = '0; store = 1'b0; overwrite = 1'b0; mux_sel = '0;
    rst = 1'b1;
    t = 0;
    model_cnt = 0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cyc(0, 0, 0, 0, 0);
  endtask

  bit rpv;

  initial begin
    @(posedge clk);
    #1;
    do_reset(4);
    idle(4);

    // single tile, full width
    do_reset(2);
    for (int c = 0; c < 25; c++) cyc(c < 5, 16, 0, 0, 0);
    check("single_tile_cnt", 32'(tile_cnt), 32'd1);
    check("single_busy", 32'(busy), 32'd0);

    // partial gating, no gating, per-sample tagging
    do_reset(2);
    for (int c = 0; c < 25; c++) cyc(c < 5, 6, 0, 0, 0);
    do_reset(2);
    for (int c = 0; c < 25; c++) cyc(c < 5, 0, 0, 0, 0);
    check("gate0_tile_cnt", 32'(tile_cnt), 32'd1);
    do_reset(2);
    for (int c = 0; c < 25; c++) cyc(c < 4, (c < 2) ? 16 : 4, 0, 0, 0);

    // command and select skew
    do_reset(2);
    for (int c = 0; c < 24; c++) cyc(0, 0, c == 0, c == 3, c == 0);

    // back-to-back tiles with one-cycle gap, then zero-gap merge
    do_reset(2);
    for (int c = 0; c < 30; c++) cyc((c < 4) || (c >= 5 && c < 9), 16, 0, 0, 0);
    check("b2b_tile_cnt", 32'(tile_cnt), 32'd2);
    for (int c = 0; c < 30; c++) cyc(c < 8, 16, 0, 0, 0);
    check("merge_tile_cnt", 32'(tile_cnt), 32'd3);

    // reset mid-tile drops the in-flight tile
    do_reset(2);
    for (int c = 0; c < 10; c++) cyc(c < 5, 16, 0, 0, 0);
    do_reset(1);
    idle(30);
    check("midreset_tile_cnt", 32'(tile_cnt), 32'd0);

    // five tiles: the 2-bit counter wraps past 3
    do_reset(2);
    for (int k = 0; k < 5; k++) for (int c = 0; c < 22; c++) cyc(c < 3, 16, 0, 0, 0);
    check("wrap_tile_cnt_w2", 32'(w_tile_cnt), 32'd1);

    // randomized bursts
    do_reset(3);
    rpv = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) rpv = ~rpv;
      cyc(rpv, $urandom_range(0, 31), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          1'($urandom));
    end
    idle(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gemm_seq_tracker.md
# gemm_seq_tracker

Parametrised control-sequencing block for the GEMM datapath. It sits beside the systolic array and replaces the fixed-size control delay chains. It skews mux selects down the array rows and delays array-valid to each accumulator bank. It gates each bank per sample by the active output-column count, skews store/overwrite per bank, and tracks tile lifetime with a small FSM, a done pulse and a tile counter.

## Interface
Parameters:
- ROWS, 16, systolic array rows; ≥2
- COLS, 16, systolic array columns
- BANK_COLS, 4, columns per accumulator bank; COLS % BANK_COLS == 0; NBANK = COLS/BANK_COLS
- MUX_W, 1, width of one mux select
- STORE_LEAD, 2, cycles that store/overwrite lead bank valid; 0 ≤ STORE_LEAD ≤ BANK_COLS-1
- CNT_W, 16, tile counter width

Ports:
- clk  in  1  clock
- rst  in  1  one clock; reset is asynchronous and active-low (rst = 0 resets)
- mux_sel  in  MUX_W  row-0 mux select
- psum_valid  in  1  array output valid (column 0)
- n_active  in  $clog2(COLS+1)  active output columns, sampled with psum_valid
- store, overwrite  in  1  accumulator commands
- mux_sel_pipe  out  [ROWS-2:0][MUX_W-1:0]  skewed selects for rows 1..ROWS-1
- bank_valid  out  NBANK  gated per-bank write valid
- bank_store, bank_overwrite  out  NBANK  skewed commands per bank
- accum_start, if_sent, acc_done  out  1  single-cycle event pulses
- busy  out  1  FSM not IDLE
- tile_cnt  out  CNT_W  completed tiles

## Operation
- mux_sel_pipe[i] = mux_sel delayed i+1 cycles.
- Valid line: valid_d[j] = psum_valid delayed j+1 cycles, j = 0..COLS-1.
- Enable line: each cycle, en[b] = (n_active > b*BANK_COLS), for b = 0..NBANK-1. en is shifted alongside valid_d, so every sample carries its own enable vector.
- bank_valid[b] = valid_d[(b+1)*BANK_COLS-1] & en_d[(b+1)*BANK_COLS-1][b].
- bank_store[b] and bank_overwrite[b] = input delayed (b+1)*BANK_COLS-STORE_LEAD cycles. These outputs are ungated.
- Event pulses:
  - accum_start = psum_valid & ~valid_d[0] (combinational).
  - if_sent = ~psum_valid & valid_d[0].
  - acc_done = tail_q & ~valid_d[COLS-1], where tail_q is valid_d[COLS-1] registered.
- n_active ≥ COLS enables all banks. n_active = 0 enables none, but every event pulse still fires.
- FSM:
  - IDLE→STREAM on psum_valid.
  - STREAM→DRAIN on !psum_valid.
  - DRAIN→STREAM on psum_valid (overlapping tiles).
  - DRAIN→IDLE when psum_valid = 0 and all valid_d = 0.
  - busy = (state != IDLE).
- tile_cnt increments at the edge closing each acc_done cycle and wraps modulo 2^CNT_W.

## Timing
- All outputs are 0 on reset: pipes, banks, pulses, busy, tile_cnt; state = IDLE.
- Reset mid-tile clears everything asynchronously. The in-flight tile produces no acc_done and no tile_cnt increment.
- psum_valid high in cycles 0..L-1:
  - bank_valid[b] is high in cycles (b+1)*BANK_COLS .. (b+1)*BANK_COLS+L-1.
  - acc_done fires at cycle COLS+L.
  - tile_cnt updates and busy falls at cycle COLS+L+1.
- A gap of ≥1 cycle between tiles gives one acc_done per tile. Zero gap merges them into one tile.
- Inputs are sampled on the rising clk edge. There is no backpressure.

## Test plan
Default parameters are used unless stated.
- Reset: hold rst=0 with random inputs → every output 0. Release rst → outputs remain 0 while inputs are idle.
- Single tile: psum_valid high for cycles 0..4, n_active=16 →
  - bank_valid[0] high 4..8, [1] high 8..12, [2] high 12..16, [3] high 16..20;
  - accum_start at 0, if_sent at 5, acc_done at 21;
  - tile_cnt=1 and busy=0 at 22.
- Gating:
  - n_active=6 → only banks 0 and 1 pulse.
  - n_active=0 → no bank_valid, but acc_done still at 21 and tile_cnt=1.
  - Tagging: cycles 0–1 with n_active=16, then cycles 2–3 with n_active=4 → bank_valid[3] high only at 16,17; bank_valid[0] high 4..7.
- Skew: mux_sel=1 at cycle 0 only → mux_sel_pipe[i]=1 only at cycle i+1. Store pulse at cycle 0 → bank_store[b] at cycle 4b+2. Same check for overwrite.
- Back-to-back tiles: psum_valid high 0..3, low at 4, high 5..8 →
  - FSM goes STREAM→DRAIN→STREAM;
  - acc_done at 20 and 25; tile_cnt=2.
- Reset mid-tile: assert rst=0 at cycle 10 of the single-tile case → all outputs 0 immediately, no acc_done afterwards, tile_cnt=0. Separately, preload tile_cnt to 2^CNT_W-1 (run with CNT_W=2) → it wraps to 0.
